// File: rtl/shift_mix_stage.sv
// AES-128 round datapath: registered ShiftRows (S1) followed by registered MixColumns (S2),
// with valid/ready flow control and a per-block bypass of MixColumns for the final round.
module shift_mix_stage #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                in_last,
  input  logic [0:3][0:3][DATA_WIDTH-1:0]     in_state,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [0:3][0:3][DATA_WIDTH-1:0]     out_state,
  output logic                                out_last,
  output logic                                busy
);

  generate
    if (DATA_WIDTH != 8) begin : g_bad_width
      $error("shift_mix_stage: DATA_WIDTH must be 8");
    end
  endgenerate

  localparam logic [DATA_WIDTH-1:0] POLY = DATA_WIDTH'(8'h1b);

  function automatic logic [DATA_WIDTH-1:0] xt(input logic [DATA_WIDTH-1:0] x);
    xt = {x[DATA_WIDTH-2:0], 1'b0} ^ (x[DATA_WIDTH-1] ? POLY : '0);
  endfunction

  logic [0:3][0:3][DATA_WIDTH-1:0] shifted;
  logic [0:3][0:3][DATA_WIDTH-1:0] mixed;
  logic [0:3][0:3][DATA_WIDTH-1:0] s1;
  logic [0:3][0:3][DATA_WIDTH-1:0] s2;
  logic s1_valid, s1_last, s2_valid, s2_last;
  logic s1_adv, s2_adv;

  genvar r, c;
  generate
    for (r = 0; r < 4; r++) begin : g_row
      for (c = 0; c < 4; c++) begin : g_col
        assign shifted[r][c] = in_state[r][(c + r) % 4];
      end
    end
    for (c = 0; c < 4; c++) begin : g_mix
      assign mixed[0][c] = xt(s1[0][c]) ^ xt(s1[1][c]) ^ s1[1][c] ^ s1[2][c] ^ s1[3][c];
      assign mixed[1][c] = s1[0][c] ^ xt(s1[1][c]) ^ xt(s1[2][c]) ^ s1[2][c] ^ s1[3][c];
      assign mixed[2][c] = s1[0][c] ^ s1[1][c] ^ xt(s1[2][c]) ^ xt(s1[3][c]) ^ s1[3][c];
      assign mixed[3][c] = xt(s1[0][c]) ^ s1[0][c] ^ s1[1][c] ^ s1[2][c] ^ xt(s1[3][c]);
    end
  endgenerate

  // in_ready is combinational from out_ready so a full pipe can push and pop in one cycle
  assign s2_adv   = !s2_valid | out_ready;
  assign s1_adv   = !s1_valid | s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1       <= '0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2       <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1      <= shifted;
          s1_last <= in_last;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        s2_last  <= s1_last;
        s2       <= s1_last ? s1 : mixed;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_last  = s2_last;
  assign out_state = s2;
  assign busy      = s1_valid | s2_valid;

endmodule
